mem_access_stage: RTL and testbench
===================================

# mem_access_stage

EX/MEM pipeline register plus load/store unit, sitting directly downstream of the execute stage. Captures the execute result, store data, destination register and write enable, then performs byte/half/word accesses to data memory over a req/ack handshake. Stalls upstream while an access is outstanding. Feeds the MEM/WB path and returns forwarding values to the execute stage.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles spent in ACCESS before abort (used only with MEM_ACCESS_TIMEOUT_EN); range 1..255.

- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-low
- Ex_Valid  in  1  valid instruction from execute
- Ex_Result  in  32  ALU/SAD result (address for memory ops)
- Ex_StoreData  in  32  forwarded rt value (store data)
- Ex_RegDest  in  5  destination register
- Ex_RegWrite  in  1  register write enable
- Ex_MemRead, Ex_MemWrite  in  1 each  load / store (MemWrite wins if both set)
- Ex_MemSize  in  2  00 word, 01 half, 10 byte, 11 word
- Ex_LoadSigned  in  1  sign-extend sub-word loads
- Stall  out  1  upstream must hold its outputs
- Mem_Req, Mem_We  out  1 each  request / write strobe
- Mem_Addr  out  32  word-aligned address
- Mem_WData  out  32  replicated store data
- Mem_ByteEn  out  4  byte lanes
- Mem_Ack  in  1  access complete (read data valid)
- Mem_RData  in  32  read word
- FW_Data  out  32  registered result (execute-stage MEM forward)
- MemLoad_Out  out  32  extracted load data, combinational from Mem_RData
- Wb_Valid, Wb_RegWrite  out  1 each  to MEM/WB
- Wb_RegDest  out  5; Wb_Data  out  32
- Misalign  out  1  one-cycle pulse
- Timeout  out  1  one-cycle pulse

## Operation
- Capture: at an edge with Ex_Valid=1 and Stall=0, load M regs (valid, result, store data, dest, controls). With Ex_Valid=0 and Stall=0, M_Valid clears. Inputs are ignored while Stall=1.
- FSM: IDLE, ACCESS.
  - IDLE→ACCESS when capturing an aligned memory op.
  - ACCESS→IDLE on an edge with Mem_Ack=1, or on abort (timeout).
  - Mem_Ack in IDLE is ignored.
- Alignment: a word op needs addr[1:0]=0 and a half op needs addr[0]=0. A misaligned op issues no request and stays IDLE. Misalign=1 in the cycle after capture, and the op retires with Wb_RegWrite=0.
- Little-endian byte lanes:
  - Mem_ByteEn: word 1111; half 0011 or 1100 by addr[1]; byte 0001<<addr[1:0].
  - Mem_WData: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
  - Mem_Addr = {M_Result[31:2],2'b00}.
  - Mem_We = store.
  - Mem_Req=1 exactly while in ACCESS.
- Load extract: Mem_RData >> 8*addr[1:0], then low byte/half sign- or zero-extended per LoadSigned. A word load passes through unchanged.
- Retire (Wb regs load at the edge):
  - non-memory op: at the edge after capture; Wb_Data=M_Result.
  - load: at the ack edge; Wb_Data=MemLoad_Out.
  - store: at the ack edge; Wb_RegWrite forced 0.
  - Otherwise Wb_Valid=0.
- FW_Data = M_Result at all times.
- Reset values: all outputs 0; FSM IDLE; M and Wb regs 0.

## Timing
- Stall = (state==ACCESS) & ~Mem_Ack (combinational). On the ack cycle upstream advances and the next instruction is captured at the same edge as retirement.
- Non-memory throughput is 1 per cycle. Capture→Wb latency is 1 edge.
- Memory op: Mem_Req rises the cycle after capture and holds until and including the ack cycle. Minimum latency (ack in first ACCESS cycle) is 1 edge after capture.
- Back-to-back memory ops: if the ack edge captures a new aligned memory op, state stays ACCESS and Mem_Req stays high with the new address.
- Reset low mid-ACCESS: the next cycle is IDLE and Mem_Req=0. A late Mem_Ack is ignored.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, the access is aborted: state→IDLE, Wb_Valid=1, Wb_RegWrite=0, and Timeout pulses for one cycle.
  - An ack on the same edge wins over the timeout.
- Undefined: no counter; ACCESS waits indefinitely; Timeout tied 0.

## Test plan
- Non-memory op: ALU ops Result=0x11, 0x22 on consecutive cycles, dest 3/4 → Wb_Data 0x11 then 0x22, one edge each, Stall never 1, FW_Data follows.
- Byte store: addr 0x1002, data 0xA5 → Mem_ByteEn=0100, Mem_WData=0xA5A5A5A5, Mem_Addr=0x1000, Mem_We=1. Ack after 3 cycles → Stall high 3 cycles, Wb_RegWrite=0.
- Signed half load: addr 0x2002, Mem_RData=0x8001_1234 → Wb_Data=0xFFFF8001. Unsigned variant → 0x00008001.
- Misaligned word load: addr 0x3001 → no Mem_Req, Misalign pulse, Wb_Valid=1, Wb_RegWrite=0.
- Reset asserted on the second cycle of ACCESS, then Mem_Ack → Mem_Req=0 the next cycle, all outputs 0, no Wb_Valid.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → Timeout pulse after 4 ACCESS cycles, Stall drops, Wb_RegWrite=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM register and load/store unit with a req/ack memory handshake.
module mem_access_stage #(parameter int unsigned TIMEOUT_CYCLES = 255) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Ex_Valid,
  input  logic [31:0] Ex_Result,
  input  logic [31:0] Ex_StoreData,
  input  logic [4:0]  Ex_RegDest,
  input  logic        Ex_RegWrite,
  input  logic        Ex_MemRead,
  input  logic        Ex_MemWrite,
  input  logic [1:0]  Ex_MemSize,
  input  logic        Ex_LoadSigned,
  output logic        Stall,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [3:0]  Mem_ByteEn,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic [31:0] FW_Data,
  output logic [31:0] MemLoad_Out,
  output logic        Wb_Valid,
  output logic        Wb_RegWrite,
  output logic [4:0]  Wb_RegDest,
  output logic [31:0] Wb_Data,
  output logic        Misalign,
  output logic        Timeout
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic m_valid, m_reg_write, m_mem_read, m_mem_write, m_load_signed;
  logic [31:0] m_result, m_store_data, shifted;
  logic [4:0] m_reg_dest;
  logic [1:0] m_mem_size;
  logic capture, ex_mem, ex_aligned, m_mem, m_aligned, m_load, abort, retire, wb_rw;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b01) ? ~a[0] : (size == 2'b10) ? 1'b1 : (a == 2'b00);
  endfunction

  assign Stall = (state == ACCESS) & ~Mem_Ack;
  assign capture = ~Stall;
  assign ex_mem = Ex_MemRead | Ex_MemWrite;
  assign ex_aligned = is_aligned(Ex_MemSize, Ex_Result[1:0]);
  assign m_mem = m_mem_read | m_mem_write;
  assign m_aligned = is_aligned(m_mem_size, m_result[1:0]);
  assign m_load = m_mem_read & ~m_mem_write;

  assign Mem_Req = (state == ACCESS);
  assign Mem_We = Mem_Req & m_mem_write;
  assign Mem_Addr = {m_result[31:2], 2'b00};
  assign Mem_WData = (m_mem_size == 2'b10) ? {4{m_store_data[7:0]}} :
                     (m_mem_size == 2'b01) ? {2{m_store_data[15:0]}} : m_store_data;
  assign Mem_ByteEn = !Mem_Req ? 4'b0000 :
                      (m_mem_size == 2'b01) ? (m_result[1] ? 4'b1100 : 4'b0011) :
                      (m_mem_size == 2'b10) ? (4'b0001 << m_result[1:0]) : 4'b1111;
  assign FW_Data = m_result;

  assign shifted = Mem_RData >> {m_result[1:0], 3'b000};
  assign MemLoad_Out = (m_mem_size == 2'b10) ? {{24{m_load_signed & shifted[7]}}, shifted[7:0]} :
                       (m_mem_size == 2'b01) ? {{16{m_load_signed & shifted[15]}}, shifted[15:0]} :
                       Mem_RData;

  always_comb begin
    state_n = (capture & Ex_Valid & ex_mem & ex_aligned) ? ACCESS :
              (Mem_Ack | abort) ? IDLE : state;
  end

  assign retire = (state == IDLE) ? (m_valid & (~m_mem | ~m_aligned)) : (Mem_Ack | abort);
  assign wb_rw = retire & ~abort & m_reg_write & ((state == IDLE) ? ~m_mem : ~m_mem_write);

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] cnt;
  assign abort = (state == ACCESS) & ~Mem_Ack & (cnt == 8'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt <= '0;
      Timeout <= 1'b0;
    end else begin
      cnt <= (state_n == ACCESS && (state == IDLE || Mem_Ack)) ? 8'd0 :
             (state == ACCESS && !Mem_Ack) ? cnt + 8'd1 : cnt;
      Timeout <= abort;
    end
  end
`else
  assign abort = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
      {m_valid, m_reg_write, m_mem_read, m_mem_write, m_load_signed} <= '0;
      {m_result, m_store_data, m_reg_dest, m_mem_size} <= '0;
      {Wb_Valid, Wb_RegWrite, Wb_RegDest, Wb_Data, Misalign} <= '0;
    end else begin
      state <= state_n;
      if (capture) m_valid <= Ex_Valid;
      if (capture && Ex_Valid) begin
        m_result <= Ex_Result;
        m_store_data <= Ex_StoreData;
        m_reg_dest <= Ex_RegDest;
        m_reg_write <= Ex_RegWrite;
        m_mem_read <= Ex_MemRead;
        m_mem_write <= Ex_MemWrite;
        m_mem_size <= Ex_MemSize;
        m_load_signed <= Ex_LoadSigned;
      end
      Wb_Valid <= retire;
      Wb_RegWrite <= wb_rw;
      if (retire) begin
        Wb_RegDest <= m_reg_dest;
        Wb_Data <= m_load ? MemLoad_Out : m_result;
      end
      Misalign <= capture & Ex_Valid & ex_mem & ~ex_aligned;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and randomized checks of mem_access_stage against a byte-lane model.
module tb_mem_access_stage;
  logic Clock = 0, Reset = 0;
  logic Ex_Valid = 0, Ex_RegWrite = 0, Ex_MemRead = 0, Ex_MemWrite = 0, Ex_LoadSigned = 0;
  logic [31:0] Ex_Result = 0, Ex_StoreData = 0, Mem_RData = 0;
  logic [4:0] Ex_RegDest = 0;
  logic [1:0] Ex_MemSize = 0;
  logic Mem_Ack = 0;
  logic Stall, Mem_Req, Mem_We, Wb_Valid, Wb_RegWrite, Misalign, Timeout;
  logic [31:0] Mem_Addr, Mem_WData, FW_Data, MemLoad_Out, Wb_Data;
  logic [3:0] Mem_ByteEn;
  logic [4:0] Wb_RegDest;
  int checks = 0, errors = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .Ex_Valid(Ex_Valid), .Ex_Result(Ex_Result),
    .Ex_StoreData(Ex_StoreData), .Ex_RegDest(Ex_RegDest), .Ex_RegWrite(Ex_RegWrite),
    .Ex_MemRead(Ex_MemRead), .Ex_MemWrite(Ex_MemWrite), .Ex_MemSize(Ex_MemSize),
    .Ex_LoadSigned(Ex_LoadSigned), .Stall(Stall), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_ByteEn(Mem_ByteEn), .Mem_Ack(Mem_Ack),
    .Mem_RData(Mem_RData), .FW_Data(FW_Data), .MemLoad_Out(MemLoad_Out), .Wb_Valid(Wb_Valid),
    .Wb_RegWrite(Wb_RegWrite), .Wb_RegDest(Wb_RegDest), .Wb_Data(Wb_Data),
    .Misalign(Misalign), .Timeout(Timeout));

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 2 : (sz == 2'd2) ? 1 : 4;
  endfunction
  function automatic bit ref_aligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % 4) % nbytes(sz) == 0;
  endfunction
  function automatic logic [3:0] ref_ben(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return (n == 4) ? 4'd15 : 4'(((1 << n) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    return (n == 4) ? d : (n == 2) ? (d & 32'hFFFF) * 32'h10001 : (d & 32'hFF) * 32'h01010101;
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sgn, input logic [31:0] a, rd);
    int n = nbytes(sz);
    longint v, span;
    if (n == 4) return rd;
    span = longint'(1) << (8 * n);
    v = (longint'(rd) >> (8 * (a % 4))) % span;
    if (sgn && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, d, input logic [1:0] sz, input logic rd, wr, sgn, rw, input logic [4:0] dst);
    Ex_Valid = 1; Ex_Result = a; Ex_StoreData = d; Ex_MemSize = sz;
    Ex_MemRead = rd; Ex_MemWrite = wr; Ex_LoadSigned = sgn; Ex_RegWrite = rw; Ex_RegDest = dst;
  endtask

  task automatic mem_op(input logic [31:0] a, d, input logic [1:0] sz, input logic wr, sgn, rw,
                        input logic [31:0] rd, input int dly);
    logic [4:0] dst = 5'($urandom);
    drive(a, d, sz, ~wr, wr, sgn, rw, dst);
    step();
    Ex_Valid = 0;
    if (!ref_aligned(sz, a)) begin
      chk("misalign_pulse", Misalign, 1);
      chk("misalign_noreq", Mem_Req, 0);
      step();
      chk("misalign_wbv", Wb_Valid, 1);
      chk("misalign_wbrw", Wb_RegWrite, 0);
      chk("misalign_clear", Misalign, 0);
      return;
    end
    chk("req", Mem_Req, 1);
    chk("addr", Mem_Addr, a & ~32'h3);
    chk("ben", Mem_ByteEn, ref_ben(sz, a));
    chk("we", Mem_We, wr);
    if (wr) chk("wdata", Mem_WData, ref_wdata(sz, d));
    for (int i = 0; i < dly; i++) begin
      chk("stall", Stall, 1);
      step();
    end
    Mem_Ack = 1; Mem_RData = rd;
    #1;
    chk("stall_ack", Stall, 0);
    if (!wr) chk("load_out", MemLoad_Out, ref_load(sz, sgn, a, rd));
    step();
    Mem_Ack = 0;
    chk("wb_valid", Wb_Valid, 1);
    chk("wb_rw", Wb_RegWrite, rw & ~wr);
    chk("wb_dest", Wb_RegDest, dst);
    if (!wr) chk("wb_data", Wb_Data, ref_load(sz, sgn, a, rd));
    chk("req_done", Mem_Req, 0);
  endtask

  initial begin
    step(); step();
    chk("rst_stall", Stall, 0);
    chk("rst_req", Mem_Req, 0);
    chk("rst_ben", Mem_ByteEn, 0);
    chk("rst_wbv", Wb_Valid, 0);
    chk("rst_fw", FW_Data, 0);
    chk("rst_mis", Misalign, 0);
    chk("rst_to", Timeout, 0);
    Reset = 1;
    step();
    drive(32'h11, 0, 0, 0, 0, 0, 1, 5'd3);
    step();
    chk("alu_fw1", FW_Data, 32'h11);
    chk("alu_stall1", Stall, 0);
    drive(32'h22, 0, 0, 0, 0, 0, 1, 5'd4);
    step();
    Ex_Valid = 0;
    chk("alu_fw2", FW_Data, 32'h22);
    chk("alu_wbv1", Wb_Valid, 1);
    chk("alu_wbd1", Wb_Data, 32'h11);
    chk("alu_dst1", Wb_RegDest, 3);
    chk("alu_rw1", Wb_RegWrite, 1);
    chk("alu_stall2", Stall, 0);
    step();
    chk("alu_wbd2", Wb_Data, 32'h22);
    chk("alu_dst2", Wb_RegDest, 4);
    Mem_Ack = 1;
    step();
    Mem_Ack = 0;
    chk("idle_ack_wbv", Wb_Valid, 0);
    chk("idle_ack_req", Mem_Req, 0);
    mem_op(32'h1002, 32'hA5, 2'b10, 1, 0, 1, 0, 3);
    mem_op(32'h2002, 0, 2'b01, 0, 1, 1, 32'h8001_1234, 1);
    chk("half_signed", Wb_Data, 32'hFFFF8001);
    mem_op(32'h2002, 0, 2'b01, 0, 0, 1, 32'h8001_1234, 0);
    chk("half_unsigned", Wb_Data, 32'h00008001);
    mem_op(32'h3001, 0, 2'b00, 0, 0, 1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      logic [1:0] sz = 2'($urandom);
      logic [31:0] a = $urandom;
      if ($urandom_range(4) != 0) a = a - (a % nbytes(sz));
      mem_op(a, $urandom, sz, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom_range(3));
    end
    drive(32'h4000, 32'h1234_5678, 2'b00, 0, 1, 0, 0, 5'd1);
    step();
    Ex_Valid = 0;
    step();
    drive(32'h5006, 0, 2'b01, 1, 0, 0, 1, 5'd9);
    Mem_Ack = 1;
    step();
    Ex_Valid = 0; Mem_Ack = 0;
    chk("b2b_req", Mem_Req, 1);
    chk("b2b_addr", Mem_Addr, 32'h5004);
    chk("b2b_ben", Mem_ByteEn, 4'b1100);
    chk("b2b_wbv", Wb_Valid, 1);
    chk("b2b_wbrw", Wb_RegWrite, 0);
    Mem_Ack = 1; Mem_RData = 32'hBEEF_0000;
    step();
    Mem_Ack = 0;
    chk("b2b_wbd", Wb_Data, 32'h0000BEEF);
    chk("b2b_dst", Wb_RegDest, 9);
    chk("b2b_done", Mem_Req, 0);
    drive(32'h6000, 0, 2'b00, 1, 0, 0, 1, 5'd7);
    step();
    Ex_Valid = 0;
    step();
    Reset = 0;
    step();
    Mem_Ack = 1;
    step();
    chk("rst_mid_req", Mem_Req, 0);
    chk("rst_mid_wbv", Wb_Valid, 0);
    chk("rst_mid_fw", FW_Data, 0);
    chk("rst_mid_addr", Mem_Addr, 0);
    chk("rst_mid_ben", Mem_ByteEn, 0);
    Reset = 1;
    step();
    Mem_Ack = 0;
    chk("late_ack_wbv", Wb_Valid, 0);
    chk("late_ack_req", Mem_Req, 0);
    chk("late_ack_stall", Stall, 0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    drive(32'h7000, 0, 2'b00, 1, 0, 0, 1, 5'd2);
    step();
    Ex_Valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", Stall, 1);
      chk("to_quiet", Timeout, 0);
      step();
    end
    chk("to_pulse", Timeout, 1);
    chk("to_stall_drop", Stall, 0);
    chk("to_wbv", Wb_Valid, 1);
    chk("to_wbrw", Wb_RegWrite, 0);
    step();
    chk("to_pulse_end", Timeout, 0);
    chk("to_no_rewb", Wb_Valid, 0);
`else
    chk("timeout_tied", Timeout, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
